// File: rtl/bit_iterator.sv
// bit_iterator: loads a word and emits its set bits one per handshake, as a
// one-hot vector plus binary index, lowest bit first or highest bit first.
module bit_iterator #(
  parameter int WORD_WIDTH   = 8,
  parameter bit SENIOR_FIRST = 1'b0,
  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [WORD_WIDTH-1:0]  data_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORD_WIDTH-1:0]  onehot_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   last_o,
  output logic [INDEX_WIDTH:0]   count_o,
  output logic                   zero_o
);

  localparam logic [WORD_WIDTH-1:0]  WORD_ONE = WORD_WIDTH'(1);
  localparam logic [INDEX_WIDTH:0]   CNT_ONE  = (INDEX_WIDTH + 1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  rem_q, rem_d;
  logic [INDEX_WIDTH:0]   cnt_q, cnt_d;
  logic                   zero_q, zero_d;

  logic [WORD_WIDTH-1:0]  pick;
  logic [INDEX_WIDTH-1:0] pick_idx;
  logic                   single;
  logic                   run;
  logic                   handshake;
  logic                   load_acc;
  logic                   ready;

  // Isolate the bit to serve next: the lowest set bit, or the highest one
  // when SENIOR_FIRST is set. The scan overwrites on every hit, so the scan
  // direction decides which set bit survives.
  function automatic logic [WORD_WIDTH-1:0] screen(input logic [WORD_WIDTH-1:0] v);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    if (SENIOR_FIRST) begin
      for (int i = 0; i < WORD_WIDTH; i++) begin
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Binary position of a one-hot vector (0 for an all-zero vector).
  function automatic logic [INDEX_WIDTH-1:0] encode(input logic [WORD_WIDTH-1:0] oh);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (oh[i]) begin
        idx = idx | INDEX_WIDTH'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_single(input logic [WORD_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WORD_ONE)) == '0);
  endfunction

  assign pick     = screen(rem_q);
  assign pick_idx = encode(pick);
  assign single   = is_single(rem_q);

  // Handshake/load qualifiers and the output view of the current bit.
  // load_ready_o depends combinationally on out_ready_i so a new word can be
  // taken in the same cycle the final bit of the old word is consumed.
  always_comb begin
    run          = (state_q == RUN);
    handshake    = run && out_ready_i;
    ready        = !run || (single && out_ready_i && !flush_i);
    load_acc     = load_valid_i && ready;
    load_ready_o = ready;
    out_valid_o  = run;
    onehot_o     = run ? pick : '0;
    index_o      = run ? pick_idx : '0;
    last_o       = run && single;
    count_o      = cnt_q;
    zero_o       = zero_q;
  end

  // Next-state logic: flush wins over everything in RUN; otherwise consume
  // the current bit on handshake, then accept a new word if one is offered.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = 1'b0;

    if (run && flush_i) begin
      state_d = IDLE;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      if (handshake) begin
        rem_d = rem_q & ~pick;
        cnt_d = cnt_q + CNT_ONE;
        if (single) begin
          state_d = IDLE;
        end
      end
      // A load is only accepted in IDLE or on the final handshake, so the
      // remaining register is empty by now and can simply be replaced.
      if (load_acc) begin
        cnt_d = '0;
        if (data_i == '0) begin
          state_d = IDLE;
          rem_d   = '0;
          zero_d  = 1'b1;
        end else begin
          state_d = RUN;
          rem_d   = data_i;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

endmodule
